// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: two-master round-robin arbiter onto one BUS slave with a per-transaction watchdog.
module bus_arbiter_2m #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     m0_addr,
    input  logic [31:0]     m1_addr,
    input  logic [31:0]     m0_wdata,
    input  logic [31:0]     m1_wdata,
    input  logic            m0_mode,
    input  logic            m1_mode,
    input  logic            m0_valid,
    input  logic            m1_valid,
    input  logic            m0_rready,
    input  logic            m1_rready,
    output logic [31:0]     m0_rdata,
    output logic [31:0]     m1_rdata,
    output logic            m0_wready,
    output logic            m1_wready,
    output logic            m0_rvalid,
    output logic            m1_rvalid,
    output logic            m0_err,
    output logic            m1_err,
    output logic [31:0]     BUS_addr,
    output logic [31:0]     BUS_wdata,
    output logic            BUS_mode,
    output logic            BUS_valid,
    output logic            BUS_rready,
    input  logic            BUS_wready,
    input  logic            BUS_rvalid,
    input  logic [31:0]     BUS_rdata,
    output logic [1:0]      grant
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_n;
    logic [1:0]      grant_n, err_n;
    logic            last, last_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic            done, expire;

    assign BUS_addr   = grant[0] ? m0_addr   : grant[1] ? m1_addr   : '0;
    assign BUS_wdata  = grant[0] ? m0_wdata  : grant[1] ? m1_wdata  : '0;
    assign BUS_mode   = grant[0] ? m0_mode   : grant[1] ? m1_mode   : 1'b0;
    assign BUS_valid  = grant[0] ? m0_valid  : grant[1] ? m1_valid  : 1'b0;
    assign BUS_rready = grant[0] ? m0_rready : grant[1] ? m1_rready : 1'b0;
    assign m0_wready  = grant[0] & BUS_wready;
    assign m1_wready  = grant[1] & BUS_wready;
    assign m0_rvalid  = grant[0] & BUS_rvalid;
    assign m1_rvalid  = grant[1] & BUS_rvalid;
    assign m0_rdata   = BUS_rdata;
    assign m1_rdata   = BUS_rdata;

    // The routed BUS_* signals already reflect the owner, so completion reads them directly.
    assign done   = BUS_mode ? BUS_wready : (BUS_rvalid & BUS_rready);
    assign expire = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        cnt_n   = cnt;
        err_n   = 2'b00;
        if (state == IDLE) begin
            if (m0_valid | m1_valid) begin
                state_n = BUSY;
                grant_n = (m0_valid & (~m1_valid | last)) ? 2'b01 : 2'b10;
                cnt_n   = '0;
            end
        end else if (done | ~BUS_valid | expire) begin
            state_n = IDLE;
            grant_n = 2'b00;
            last_n  = grant[1];
            cnt_n   = '0;
            err_n   = (expire & BUS_valid & ~done) ? grant : 2'b00;
        end else begin
            cnt_n = cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 2'b00;
            last   <= 1'b1;
            cnt    <= '0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            last   <= last_n;
            cnt    <= cnt_n;
            m0_err <= err_n[0];
            m1_err <= err_n[1];
        end
    end
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: directed cycle tables plus a random run against a transaction-level reference model.
module tb_bus_arbiter_2m;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_mode, m1_mode, m0_valid, m1_valid, m0_rready, m1_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_wready, m1_wready, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] BUS_addr, BUS_wdata, BUS_rdata;
    logic        BUS_mode, BUS_valid, BUS_rready, BUS_wready, BUS_rvalid;
    logic [1:0]  grant;

    bus_arbiter_2m #(.TIMEOUT(TMO), .TO_W(16)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_mode(m0_mode), .m1_mode(m1_mode), .m0_valid(m0_valid), .m1_valid(m1_valid),
        .m0_rready(m0_rready), .m1_rready(m1_rready), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_wready(m0_wready), .m1_wready(m1_wready), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_err(m0_err), .m1_err(m1_err), .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata),
        .BUS_mode(BUS_mode), .BUS_valid(BUS_valid), .BUS_rready(BUS_rready),
        .BUS_wready(BUS_wready), .BUS_rvalid(BUS_rvalid), .BUS_rdata(BUS_rdata), .grant(grant)
    );

    // in  = {rst, v0, mode0, v1, mode1, rready0, rready1, BUS_wready, BUS_rvalid}
    // out = {grant[1:0], BUS_valid, wready0, wready1, rvalid0, rvalid1, err0, err1}
    typedef struct packed {
        logic [8:0] in;
        logic [8:0] out;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0, miscompares = 0;

    // Reference model: who owns the bus, how long it has held it, who owned it last.
    int own = -1, last = 1, age = 0, errm = -1;

    task automatic add(input logic [8:0] in, input logic [8:0] out, input int n = 1);
        for (int i = 0; i < n; i++) tbl.push_back('{in, out});
    endtask

    task automatic apply(input logic [8:0] in);
        {rst, m0_valid, m0_mode, m1_valid, m1_mode, m0_rready, m1_rready, BUS_wready, BUS_rvalid} = in;
    endtask

    function automatic logic [8:0] flags();
        return {grant, BUS_valid, m0_wready, m1_wready, m0_rvalid, m1_rvalid, m0_err, m1_err};
    endfunction

    task automatic model_update();
        bit v, md, rr, fin;
        fin = 0;
        if (rst) begin
            own = -1; last = 1; age = 0; errm = -1;
        end else begin
            errm = -1;
            if (own < 0) begin
                if (m0_valid && m1_valid) own = 1 - last;
                else if (m0_valid) own = 0;
                else if (m1_valid) own = 1;
                age = 0;
            end else begin
                v  = own == 1 ? m1_valid  : m0_valid;
                md = own == 1 ? m1_mode   : m0_mode;
                rr = own == 1 ? m1_rready : m0_rready;
                if ((md ? BUS_wready : (BUS_rvalid && rr)) || !v) fin = 1;
                else if (age + 1 == TMO) begin errm = own; fin = 1; end
                else age++;
                if (fin) begin last = own; own = -1; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model();
        logic [140:0] exp_v, act_v;
        logic         o0, o1;
        o0 = own == 0;
        o1 = own == 1;
        exp_v = {o1, o0, o0 ? m0_valid : o1 ? m1_valid : 1'b0,
                 o0 && BUS_wready, o1 && BUS_wready, o0 && BUS_rvalid, o1 && BUS_rvalid,
                 errm == 0, errm == 1,
                 o0 ? m0_addr : o1 ? m1_addr : 32'h0,
                 o0 ? m0_wdata : o1 ? m1_wdata : 32'h0,
                 o0 ? m0_mode : o1 ? m1_mode : 1'b0,
                 o0 ? m0_rready : o1 ? m1_rready : 1'b0,
                 BUS_rdata, BUS_rdata};
        act_v = {flags(), BUS_addr, BUS_wdata, BUS_mode, BUS_rready, m0_rdata, m1_rdata};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL rand@%0t got %h want %h", $time, act_v, exp_v);
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        m0_addr = 32'h10; m0_wdata = 32'hA5A5A5A5; m1_addr = 32'h20; m1_wdata = 32'h5A5A5A5A;
        BUS_rdata = 32'h12345678;
        apply(9'b0);

        // reset and idle
        add(9'b1_00_00_00_00, 9'b00_0_00_00_00, 2);
        add(9'b0_00_00_00_00, 9'b00_0_00_00_00);
        // both read at once: M0 wins, one idle gap, then M1; M1 read returns data
        add(9'b0_10_10_11_00, 9'b00_0_00_00_00);
        add(9'b0_10_10_11_00, 9'b01_1_00_00_00, 3);
        add(9'b0_10_10_11_01, 9'b01_1_00_10_00);
        add(9'b0_00_10_11_00, 9'b00_0_00_00_00);
        add(9'b0_00_10_11_00, 9'b10_1_00_00_00);
        add(9'b0_00_10_11_01, 9'b10_1_00_01_00);
        add(9'b0_00_00_00_00, 9'b00_0_00_00_00);
        // m0 write, slave accepts two cycles after grant
        add(9'b0_11_00_00_00, 9'b00_0_00_00_00);
        add(9'b0_11_00_00_00, 9'b01_1_00_00_00, 2);
        add(9'b0_11_00_00_10, 9'b01_1_10_00_00);
        add(9'b0_00_00_00_00, 9'b00_0_00_00_00);
        // m0 read never answered: 8 busy cycles, err pulse, pending m1 then granted
        add(9'b0_10_00_10_00, 9'b00_0_00_00_00);
        add(9'b0_10_10_10_00, 9'b01_1_00_00_00, 8);
        add(9'b0_00_11_00_00, 9'b00_0_00_00_10);
        add(9'b0_00_11_00_00, 9'b10_1_00_00_00);
        add(9'b0_00_11_00_10, 9'b10_1_01_00_00);
        add(9'b0_00_00_00_00, 9'b00_0_00_00_00);
        // reset during an M1 write, then tie goes to M0, which withdraws; pending M1 follows
        add(9'b0_00_11_00_00, 9'b00_0_00_00_00);
        add(9'b0_00_11_00_00, 9'b10_1_00_00_00);
        add(9'b1_00_11_00_00, 9'b10_1_00_00_00);
        add(9'b0_10_10_11_10, 9'b00_0_00_00_00);
        add(9'b0_10_10_11_00, 9'b01_1_00_00_00);
        add(9'b0_00_10_11_00, 9'b01_0_00_00_00);
        add(9'b0_00_10_11_00, 9'b00_0_00_00_00);
        add(9'b0_00_10_11_00, 9'b10_1_00_00_00);
        add(9'b0_00_10_11_01, 9'b10_1_00_01_00);
        add(9'b0_00_00_00_00, 9'b00_0_00_00_00);

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            #4;
            exp_addr = tbl[i].out[8:7] == 2'b01 ? 32'h10 : tbl[i].out[8:7] == 2'b10 ? 32'h20 : 32'h0;
            vectors++;
            if ({flags(), BUS_addr, m0_rdata, m1_rdata} !== {tbl[i].out, exp_addr, 32'h12345678, 32'h12345678}) begin
                miscompares++;
                $display("FAIL row%0d got flags %b addr %h want flags %b addr %h",
                         i, flags(), BUS_addr, tbl[i].out, exp_addr);
            end
            tick();
        end

        apply(9'b1_00_00_00_00);
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst        = $urandom_range(0, 199) == 0;
            m0_valid   = $urandom_range(0, 9) != 0;
            m1_valid   = $urandom_range(0, 9) != 0;
            m0_mode    = 1'($urandom);
            m1_mode    = 1'($urandom);
            m0_rready  = $urandom_range(0, 3) != 0;
            m1_rready  = $urandom_range(0, 3) != 0;
            BUS_wready = $urandom_range(0, 5) == 0;
            BUS_rvalid = $urandom_range(0, 5) == 0;
            m0_addr    = $urandom; m1_addr  = $urandom;
            m0_wdata   = $urandom; m1_wdata = $urandom;
            BUS_rdata  = $urandom;
            #4;
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
